// File: rtl/acc_muldiv_seq.sv
// Micro-step sequencer for 4x4 unsigned multiply (shift-add) and restoring divide
// on a split high/low accumulator; one accumulator/ALU control word per clock.
module acc_muldiv_seq #(
  parameter int N_BITS = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       op,
  input  logic       abort,
  input  logic       divisor_zero,
  input  logic       alu_carry,
  input  logic       acc_low_lsb,
  output logic       busy,
  output logic       done,
  output logic       div_err,
  output logic       acc_in_select,
  output logic [1:0] acc_high_select,
  output logic [1:0] acc_low_select,
  output logic       fill_value,
  output logic       acc_high_reset_p,
  output logic       alu_sub
);
  localparam int CW = $clog2(N_BITS) + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_COPY, S_CLEAR, S_ADD, S_SHR,
    S_SHL, S_SUB, S_FINAL, S_DONE, S_ERR
  } state_t;

  localparam logic [1:0] SEL_HOLD = 2'b00, SEL_SHR = 2'b01,
                         SEL_SHL  = 2'b10, SEL_LOAD = 2'b11;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic            r_op, r_carry_q, r_q_q, r_hrst;
  logic            w_last;

  assign w_last = (r_cnt == CW'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= 1'b0;
      r_carry_q <= 1'b0;
      r_q_q     <= 1'b0;
      r_hrst    <= 1'b0;
    end else begin
      r_state <= w_next;
      // Registered so the high-half clear is glitch-free in CLEAR.
      r_hrst  <= (w_next == S_CLEAR);
      if (r_state == S_IDLE && start) r_op <= op;
      case (r_state)
        S_CLEAR: begin
          r_cnt     <= CW'(N_BITS);
          r_carry_q <= 1'b0;
          r_q_q     <= 1'b0;
        end
        S_ADD: r_carry_q <= acc_low_lsb & alu_carry;
        S_SHR: r_cnt     <= r_cnt - CW'(1);
        S_SUB: begin
          r_cnt <= r_cnt - CW'(1);
          r_q_q <= alu_carry;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (op && divisor_zero) ? S_ERR : S_LOAD;
      S_LOAD:  w_next = S_COPY;
      S_COPY:  w_next = S_CLEAR;
      S_CLEAR: w_next = r_op ? S_SHL : S_ADD;
      S_ADD:   w_next = S_SHR;
      S_SHR:   w_next = w_last ? S_DONE : S_ADD;
      S_SHL:   w_next = S_SUB;
      S_SUB:   w_next = w_last ? S_FINAL : S_SHL;
      S_FINAL: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (abort && r_state != S_IDLE) w_next = S_IDLE;
  end

  always_comb begin
    busy            = (r_state != S_IDLE);
    done            = (r_state == S_DONE) || (r_state == S_ERR);
    div_err         = (r_state == S_ERR);
    acc_in_select   = 1'b0;
    acc_high_select = SEL_HOLD;
    acc_low_select  = SEL_HOLD;
    fill_value      = 1'b0;
    alu_sub         = 1'b0;
    case (r_state)
      S_LOAD: begin
        acc_in_select   = 1'b1;
        acc_high_select = SEL_LOAD;
      end
      S_COPY: acc_low_select = SEL_LOAD;
      S_ADD:  if (acc_low_lsb) acc_high_select = SEL_LOAD;
      S_SHR: begin
        acc_high_select = SEL_SHR;
        acc_low_select  = SEL_SHR;
        fill_value      = r_carry_q;
      end
      S_SHL: begin
        acc_high_select = SEL_SHL;
        acc_low_select  = SEL_SHL;
        fill_value      = r_q_q;
      end
      S_SUB: begin
        alu_sub = 1'b1;
        if (alu_carry) acc_high_select = SEL_LOAD;
      end
      S_FINAL: begin
        acc_low_select = SEL_SHL;
        fill_value     = r_q_q;
      end
      default: ;
    endcase
  end

  assign acc_high_reset_p = r_hrst;
endmodule

// File: tb/tb_acc_muldiv_seq.sv
// Bench for acc_muldiv_seq: accumulator/ALU environment, cycle-level timing model,
// arithmetic result checks and directed literal cases plus randomized operations.
module tb_acc_muldiv_seq;
  logic       clk = 1'b0;
  logic       reset_n, start, op_i, abort;
  logic       divisor_zero, alu_carry, acc_low_lsb;
  logic       busy, done, div_err, acc_in_select, fill_value, acc_high_reset_p, alu_sub;
  logic [1:0] acc_high_select, acc_low_select;

  logic [3:0] bus, bval, acc_h, acc_l, alu_res;
  int nchk = 0, nerr = 0;

  acc_muldiv_seq #(.N_BITS(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op_i), .abort(abort),
    .divisor_zero(divisor_zero), .alu_carry(alu_carry), .acc_low_lsb(acc_low_lsb),
    .busy(busy), .done(done), .div_err(div_err), .acc_in_select(acc_in_select),
    .acc_high_select(acc_high_select), .acc_low_select(acc_low_select),
    .fill_value(fill_value), .acc_high_reset_p(acc_high_reset_p), .alu_sub(alu_sub)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Accumulator + ALU environment (A = high half, B = bval).
  assign divisor_zero = (bval == 4'd0);
  assign acc_low_lsb  = acc_l[0];
  assign alu_res      = alu_sub ? (acc_h - bval) : (acc_h + bval);
  assign alu_carry    = alu_sub ? (acc_h >= bval) : ((5'(acc_h) + 5'(bval)) > 5'd15);

  always @(posedge clk) begin
    if (acc_high_reset_p) acc_h <= 4'd0;
    else case (acc_high_select)
      2'b01: acc_h <= {fill_value, acc_h[3:1]};
      2'b10: acc_h <= {acc_h[2:0], acc_l[3]};
      2'b11: acc_h <= acc_in_select ? bus : alu_res;
      default: ;
    endcase
    case (acc_low_select)
      2'b01: acc_l <= {acc_h[0], acc_l[3:1]};
      2'b10: acc_l <= {acc_l[2:0], fill_value};
      2'b11: acc_l <= acc_h;
      default: ;
    endcase
  end

  // Timing model: cycles left in the current operation (0 = idle).
  // kind 0 = MUL (12 cycles), 1 = DIV (13), 2 = divide-by-zero (1).
  int rem = 0, kind = 0;
  function automatic int op_len(input int k);
    return (k == 0) ? 12 : (k == 1) ? 13 : 1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) rem <= 0;
    else if (rem == 0) begin
      if (start) begin
        kind <= op_i ? (divisor_zero ? 2 : 1) : 0;
        rem  <= op_len(op_i ? (divisor_zero ? 2 : 1) : 0);
      end
    end else rem <= abort ? 0 : rem - 1;
  end

  always @(negedge clk) begin
    check("busy", int'(busy), int'(rem != 0));
    check("done", int'(done), int'(rem == 1));
    check("div_err", int'(div_err), int'(rem == 1 && kind == 2));
    check("high_reset", int'(acc_high_reset_p),
          int'(rem != 0 && kind != 2 && rem == op_len(kind) - 2));
    if (rem == 0 || kind == 2)
      check("idle_ctl", int'({acc_in_select, acc_high_select, acc_low_select, fill_value, alu_sub}), 0);
  end

  task automatic run(input bit o, input logic [3:0] a, input logic [3:0] b,
                     input int abort_at, input bit poke,
                     output logic [3:0] rh, output logic [3:0] rl, output int dc);
    logic [3:0] h0, l0;
    int cyc, len;
    bit seen, err;
    len = o ? ((b == 0) ? 1 : 13) : 12;
    @(posedge clk); #2;
    bus = a; bval = b; op_i = o; start = 1'b1;
    h0 = acc_h; l0 = acc_l;
    @(posedge clk); #2;
    start = 1'b0; cyc = 1; seen = 0; err = 0; dc = 0; rh = 'x; rl = 'x;
    while (!seen && cyc <= 20) begin
      if (cyc == abort_at) abort = 1'b1;
      if (poke && cyc == 5) begin start = 1'b1; op_i = ~o; end
      @(negedge clk);
      if (done) begin seen = 1; err = div_err; rh = acc_h; rl = acc_l; dc = cyc; end
      @(posedge clk); #2;
      abort = 1'b0; start = 1'b0; op_i = o; cyc++;
    end
    if (abort_at > 0) check("abort_no_done", int'(seen), 0);
    else begin
      check("done_seen", int'(seen), 1);
      check("latency", dc, len);
      if (!o) check("mul_product", int'({rh, rl}), int'(a) * int'(b));
      else if (b == 0) begin
        check("dz_err", int'(err), 1);
        check("dz_acc_untouched", int'({rh, rl}), int'({h0, l0}));
      end else begin
        check("div_err_clear", int'(err), 0);
        check("div_quot", int'(rl), int'(a) / int'(b));
        check("div_rem", int'(rh), int'(a) % int'(b));
      end
    end
  endtask

  initial begin
    logic [3:0] h, l;
    int dc;
    bit o;
    logic [3:0] a, b;
    reset_n = 1'b0; start = 1'b0; op_i = 1'b0; abort = 1'b0;
    bus = 4'd0; bval = 4'd1; acc_h = 4'd0; acc_l = 4'd0;
    #1;
    check("reset_outs", int'({busy, done, div_err, acc_in_select, acc_high_select,
                              acc_low_select, fill_value, acc_high_reset_p, alu_sub}), 0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;

    run(0, 4'hD, 4'hB, 0, 0, h, l, dc);
    check("mul13x11_hi", int'(h), 8); check("mul13x11_lo", int'(l), 15);
    check("mul13x11_lat", dc, 12);
    run(0, 4'hF, 4'hF, 0, 0, h, l, dc);
    check("mul15x15_hi", int'(h), 14); check("mul15x15_lo", int'(l), 1);
    run(0, 4'h0, 4'h7, 0, 0, h, l, dc);
    check("mul0x7", int'({h, l}), 0);
    run(1, 4'd13, 4'd3, 0, 0, h, l, dc);
    check("div13_3_q", int'(l), 4); check("div13_3_r", int'(h), 1);
    check("div13_3_lat", dc, 13);
    run(1, 4'd15, 4'd1, 0, 0, h, l, dc);
    check("div15_1_q", int'(l), 15); check("div15_1_r", int'(h), 0);
    run(1, 4'd14, 4'd11, 0, 0, h, l, dc);
    check("div14_11_q", int'(l), 1); check("div14_11_r", int'(h), 3);
    run(1, 4'd9, 4'd0, 0, 0, h, l, dc);
    check("dz_lat", dc, 1);
    run(0, 4'd7, 4'd9, 0, 1, h, l, dc);
    check("mul_poke", int'({h, l}), 63);
    run(0, 4'd5, 4'd6, 6, 0, h, l, dc);

    // Async reset while the DIV is in its first SUB step.
    @(posedge clk); #2;
    bus = 4'd13; bval = 4'd3; op_i = 1'b1; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 check("pre_reset_sub", int'(alu_sub), 1);
    #1 reset_n = 1'b0;
    #1 check("async_reset_outs", int'({busy, done, div_err, acc_in_select, acc_high_select,
                                      acc_low_select, fill_value, acc_high_reset_p, alu_sub}), 0);
    @(posedge clk); #3 reset_n = 1'b1;
    run(0, 4'd2, 4'd3, 0, 0, h, l, dc);
    check("mul2x3_after_reset", int'({h, l}), 6);

    for (int i = 0; i < 60; i++) begin
      o = 1'($urandom_range(0, 1));
      a = 4'($urandom_range(0, 15));
      b = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      if (o && b == 0) run(o, a, b, 0, 0, h, l, dc);
      else if ($urandom_range(0, 5) == 0)
        run(o, a, b, $urandom_range(1, o ? 12 : 11), 0, h, l, dc);
      else run(o, a, b, 0, 1'($urandom_range(0, 1)), h, l, dc);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, limit %0d ns", 500000);
    $fatal(1, "watchdog");
  end
endmodule
